mem_access_seq: RTL and testbench

- Multicycle sequencer that owns the data-memory port, the MDR and the load/store sizing path.
- Accepts one load or store request from the main control FSM, issues the word-aligned memory access, and waits a fixed memory latency.
- Loads: extracts and extends the addressed byte, halfword or word. Sub-word stores: performs a read-modify-write.
- Reports completion with a one-cycle done pulse, plus a misalignment/illegal-size flag.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_access_seq_if.sv | 25 ++
 rtl/mem_access_seq_lane_align.sv | 49 ++++
 rtl/mem_access_seq.sv | 122 ++++++++++++
 tb/tb_mem_access_seq.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access sequencer.
package mem_pkg;

  localparam logic [1:0] SZ_ILL  = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  localparam int MEM_LAT_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_MERGE   = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } seq_state_t;

  // Illegal size code or a halfword/word that does not sit on its natural boundary.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// Request/response handshake between the main control FSM and the memory access sequencer.
interface mem_access_seq_if;

  logic        req;
  logic        op_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, op_store, size, sign_ext, addr, wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  req, op_store, size, sign_ext, addr, wdata,
    output busy, done, err, rdata
  );

endinterface

// File: rtl/mem_access_seq_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [15:0] sdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (offset)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_val = word;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        load_val = {{24{sign_ext & lane_b[7]}}, lane_b};
        case (offset)
          2'd0:    merged[7:0]   = sdata[7:0];
          2'd1:    merged[15:8]  = sdata[7:0];
          2'd2:    merged[23:16] = sdata[7:0];
          default: merged[31:24] = sdata[7:0];
        endcase
      end
      SZ_HALF: begin
        load_val = {{16{sign_ext & lane_h[15]}}, lane_h};
        if (offset[1]) merged[31:16] = sdata;
        else           merged[15:0]  = sdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer owning the data-memory port, the MDR and sizing path.
//
// state   | meaning
// IDLE    | waiting for req; latches the request and checks alignment
// RD_WAIT | word read outstanding for MEM_LAT cycles; MDR captured on the last one
// MERGE   | sub-word store: addressed lane of MDR replaced with store data
// WRITE   | mem_wr asserted for one cycle
// DONE    | done pulse; load result registered; always back to IDLE
module mem_access_seq
  import mem_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mem_access_seq_if.slave       rq,
  output logic [31:0]           mem_addr,
  output logic                  mem_wr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [2:0] ST_IDLE    = S_IDLE;
  localparam logic [2:0] ST_RD_WAIT = S_RD_WAIT;
  localparam logic [2:0] ST_MERGE   = S_MERGE;
  localparam logic [2:0] ST_WRITE   = S_WRITE;
  localparam logic [2:0] ST_DONE    = S_DONE;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT - 1);

  logic [2:0]    state;
  logic          op_store_q;
  logic [1:0]    size_q;
  logic          sign_ext_q;
  logic [1:0]    off_q;
  logic [15:0]   wdata_q;
  logic          err_q;
  logic [31:0]   mdr;
  logic [CW-1:0] lat_cnt;
  logic [31:0]   rdata_q;
  logic          acc_err;
  logic [31:0]   load_val;
  logic [31:0]   merged;

  assign acc_err = access_err(rq.size, rq.addr[1:0]);

  lane_align u_lane_align (
    .word     (mdr),
    .offset   (off_q),
    .size     (size_q),
    .sign_ext (sign_ext_q),
    .sdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      op_store_q <= 1'b0;
      size_q     <= SZ_ILL;
      sign_ext_q <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      mdr        <= '0;
      lat_cnt    <= '0;
      rdata_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rq.req) begin
            op_store_q <= rq.op_store;
            size_q     <= rq.size;
            sign_ext_q <= rq.sign_ext;
            off_q      <= rq.addr[1:0];
            wdata_q    <= rq.wdata[15:0];
            err_q      <= acc_err;
            lat_cnt    <= LAT_INIT;
            mem_addr   <= {rq.addr[31:2], 2'b00};
            if (acc_err) begin
              state <= ST_DONE;
            end else if (rq.op_store && (rq.size == SZ_WORD)) begin
              mem_wdata <= rq.wdata;
              state     <= ST_WRITE;
            end else begin
              state <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt == '0) begin
            mdr   <= mem_rdata;
            state <= op_store_q ? ST_MERGE : ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end
        ST_MERGE: begin
          mem_wdata <= merged;
          state     <= ST_WRITE;
        end
        ST_WRITE: state <= ST_DONE;
        ST_DONE: begin
          if (!op_store_q && !err_q) rdata_q <= load_val;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rq.busy  = (state != ST_IDLE);
  assign rq.done  = (state == ST_DONE);
  assign rq.err   = (state == ST_DONE) && err_q;
  assign rq.rdata = rdata_q;
  assign mem_wr   = (state == ST_WRITE);

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed table-driven bench for mem_access_seq with hand-computed expectations.
module tb_mem_access_seq;
  import mem_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_seq_if rq();

  mem_access_seq #(.MEM_LAT(LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rq        (rq),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  logic [31:0] wr_data = '0;
  logic [31:0] wr_addr = '0;
  logic [31:0] model_rdata = '0;

  always @(negedge clk) begin
    if (mem_wr) begin
      wr_cnt  = wr_cnt + 1;
      wr_data = mem_wdata;
      wr_addr = mem_addr;
    end
  end

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mw;
    logic        e;
    logic [31:0] rd;
    int          lat;
    logic        wr;
    logic [31:0] mwd;
  } vec_t;

  vec_t v[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_acc(input vec_t x, input string nm);
    int k;
    logic got;
    int wr0;
    @(negedge clk);
    rq.req      = 1'b1;
    rq.op_store = x.st;
    rq.size     = x.sz;
    rq.sign_ext = x.sx;
    rq.addr     = x.a;
    rq.wdata    = x.wd;
    mem_rdata   = x.mw;
    wr0 = wr_cnt;
    k = 0;
    got = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      if (rq.done) got = 1'b1;
      else chk({nm, " err_without_done"}, 32'(rq.err), 32'h0);
    end
    chk({nm, " latency"}, 32'(k), 32'(x.lat));
    chk({nm, " err"}, 32'(rq.err), 32'(x.e));
    chk({nm, " mem_addr"}, mem_addr, {x.a[31:2], 2'b00});
    rq.req = 1'b0;
    if (!x.st && !x.e) model_rdata = x.rd;
    @(negedge clk);
    chk({nm, " busy_after"}, 32'(rq.busy), 32'h0);
    chk({nm, " rdata"}, rq.rdata, model_rdata);
    chk({nm, " wr_count"}, 32'(wr_cnt - wr0), x.wr ? 32'd1 : 32'd0);
    if (x.wr) begin
      chk({nm, " wr_data"}, wr_data, x.mwd);
      chk({nm, " wr_addr"}, wr_addr, {x.a[31:2], 2'b00});
    end
  endtask

  initial begin
    int k;
    int wr_save;
    logic got;

    v[0]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1'b0, 32'hFFFF_FF80, LAT+1, 1'b0, 32'h0};
    v[1]  = '{1'b1, SZ_WORD, 1'b0, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 2, 1'b1, 32'hDEAD_BEEF};
    v[2]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1'b0, 32'h0000_0080, LAT+1, 1'b0, 32'h0};
    v[3]  = '{1'b0, SZ_HALF, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_0001, 1'b0, 32'hFFFF_BEEF, LAT+1, 1'b0, 32'h0};
    v[4]  = '{1'b0, SZ_HALF, 1'b1, 32'h0000_2000, 32'h0, 32'hBEEF_0001, 1'b0, 32'h0000_0001, LAT+1, 1'b0, 32'h0};
    v[5]  = '{1'b0, SZ_HALF, 1'b0, 32'h0000_2002, 32'h0, 32'hBEEF_0001, 1'b0, 32'h0000_BEEF, LAT+1, 1'b0, 32'h0};
    v[6]  = '{1'b0, SZ_WORD, 1'b1, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, LAT+1, 1'b0, 32'h0};
    v[7]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0000_1002, 32'h0, 32'h80FF_1234, 1'b0, 32'h0000_00FF, LAT+1, 1'b0, 32'h0};
    v[8]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_1001, 32'h0, 32'h80FF_1234, 1'b0, 32'h0000_0012, LAT+1, 1'b0, 32'h0};
    v[9]  = '{1'b0, SZ_HALF, 1'b1, 32'h0000_6001, 32'h0, 32'h5555_AAAA, 1'b1, 32'h0, 1, 1'b0, 32'h0};
    v[10] = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_4001, 32'h0000_00AA, 32'h1122_3344, 1'b0, 32'h0, LAT+3, 1'b1, 32'h1122_AA44};
    v[11] = '{1'b1, SZ_HALF, 1'b0, 32'h0000_4002, 32'hFFFF_1357, 32'h1122_3344, 1'b0, 32'h0, LAT+3, 1'b1, 32'h1357_3344};
    v[12] = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_4003, 32'h1234_5678, 32'h1122_3344, 1'b0, 32'h0, LAT+3, 1'b1, 32'h7822_3344};
    v[13] = '{1'b1, SZ_HALF, 1'b0, 32'h0000_4000, 32'h0000_ABCD, 32'h1122_3344, 1'b0, 32'h0, LAT+3, 1'b1, 32'h1122_ABCD};
    v[14] = '{1'b1, SZ_WORD, 1'b0, 32'h0000_6002, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'h0, 1, 1'b0, 32'h0};
    v[15] = '{1'b0, SZ_ILL,  1'b0, 32'h0000_6000, 32'h0, 32'h1234_5678, 1'b1, 32'h0, 1, 1'b0, 32'h0};
    v[16] = '{1'b1, SZ_HALF, 1'b0, 32'h0000_6003, 32'h0000_FFFF, 32'h0, 1'b1, 32'h0, 1, 1'b0, 32'h0};
    v[17] = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_1000, 32'h0, 32'h80FF_1234, 1'b0, 32'h0000_0034, LAT+1, 1'b0, 32'h0};

    rq.req = 1'b0; rq.op_store = 1'b0; rq.size = SZ_ILL; rq.sign_ext = 1'b0;
    rq.addr = '0; rq.wdata = '0; mem_rdata = '0;
    #1 reset_n = 1'b0;
    #11;
    chk("reset busy", 32'(rq.busy), 32'h0);
    chk("reset done", 32'(rq.done), 32'h0);
    chk("reset mem_wr", 32'(mem_wr), 32'h0);
    chk("reset rdata", rq.rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    do_acc(v[0], "load_b3_sx");
    do_acc(v[1], "store_word");

    // Sub-word store aborted by reset while the read is outstanding.
    @(negedge clk);
    rq.req = 1'b1; rq.op_store = 1'b1; rq.size = SZ_BYTE; rq.sign_ext = 1'b0;
    rq.addr = 32'h0000_4001; rq.wdata = 32'h0000_00AA; mem_rdata = 32'h1122_3344;
    wr_save = wr_cnt;
    @(negedge clk);
    chk("abort in_rd_wait busy", 32'(rq.busy), 32'h1);
    #2 reset_n = 1'b0;
    rq.req = 1'b0;
    #1;
    chk("abort busy", 32'(rq.busy), 32'h0);
    chk("abort done", 32'(rq.done), 32'h0);
    chk("abort err", 32'(rq.err), 32'h0);
    chk("abort mem_wr", 32'(mem_wr), 32'h0);
    chk("abort rdata", rq.rdata, 32'h0);
    chk("abort mem_addr", mem_addr, 32'h0);
    chk("abort mem_wdata", mem_wdata, 32'h0);
    model_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort no_write", 32'(wr_cnt - wr_save), 32'h0);

    for (int i = 2; i < 18; i++) do_acc(v[i], $sformatf("vec%0d", i));

    // req held high across DONE: next accept only after one IDLE cycle.
    @(negedge clk);
    rq.req = 1'b1; rq.op_store = 1'b0; rq.size = SZ_WORD; rq.sign_ext = 1'b0;
    rq.addr = 32'h0000_7000; mem_rdata = 32'h0123_4567;
    k = 0; got = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      if (rq.done) got = 1'b1;
    end
    chk("b2b first latency", 32'(k), 32'(LAT+1));
    chk("b2b busy in done", 32'(rq.busy), 32'h1);
    rq.size = SZ_BYTE; rq.sign_ext = 1'b1; rq.addr = 32'h0000_7005; mem_rdata = 32'h0000_9900;
    @(negedge clk);
    chk("b2b idle busy", 32'(rq.busy), 32'h0);
    chk("b2b idle done", 32'(rq.done), 32'h0);
    chk("b2b first rdata", rq.rdata, 32'h0123_4567);
    @(negedge clk);
    chk("b2b second accepted", 32'(rq.busy), 32'h1);
    k = 1; got = rq.done;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      if (rq.done) got = 1'b1;
    end
    chk("b2b second latency", 32'(k), 32'(LAT+1));
    chk("b2b second mem_addr", mem_addr, 32'h0000_7004);
    rq.req = 1'b0;
    @(negedge clk);
    chk("b2b second rdata", rq.rdata, 32'hFFFF_FF99);
    chk("b2b second busy", 32'(rq.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
